mux4_scan_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the 4:1 select mux (mux4).
- Accepts 4-bit parallel words over a valid/ready handshake and holds each word on the mux data input.
- Steps the 2-bit select through all four positions and presents the mux output as a serial bit stream with its own valid/ready handshake.
- Reassembles the returned bits into a word and flags any mismatch between the returned bit and the expected data bit. This gives a self-checking drive/consume loop around the downstream mux.

---
 rtl/mux4_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_mux4_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: drives a downstream 4:1 mux with one parallel word at a
// time, walks the select through all four inputs, streams the mux output as
// serial bits, and rebuilds the word from those bits while checking each
// returned bit against the bit that was driven.
module mux4_scan_ctrl #(
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [1:0] mux_s,
    output logic [3:0] mux_d,
    input  logic       mux_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last,
    output logic       word_done,
    output logic [3:0] word_out,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Select value the scan begins (and ends, after wrapping) on.
    localparam logic [1:0] S_START = LSB_FIRST ? 2'd0 : 2'd3;
    // Terminal count of the idle gap; only meaningful when a gap is configured.
    localparam int unsigned GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [3:0]  GAP_LAST   = GAP_LAST_I[3:0];

    state_t     state_q,     state_d;
    logic [1:0] mux_s_q,     mux_s_d;
    logic [3:0] mux_d_q,     mux_d_d;
    logic [1:0] bit_cnt_q,   bit_cnt_d;
    logic [3:0] gap_cnt_q,   gap_cnt_d;
    logic [3:0] asm_q,       asm_d;
    logic [3:0] word_out_q,  word_out_d;
    logic       word_done_q, word_done_d;
    logic       err_q,       err_d;
    logic       in_ready_q,  in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q,  out_last_d;

    // Next-state logic for the sequencer and all of its registered outputs.
    always_comb begin
        state_d     = state_q;
        mux_s_d     = mux_s_q;
        mux_d_d     = mux_d_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        asm_d       = asm_q;
        word_out_d  = word_out_q;
        word_done_d = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mux_d_d   = in_data;
                    mux_s_d   = S_START;
                    bit_cnt_d = 2'd0;
                    asm_d     = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    // Assemble into a shadow register so word_out only changes
                    // when a whole word has come back.
                    asm_d[mux_s_q] = mux_y;
                    if (mux_y != mux_d_q[mux_s_q]) begin
                        err_d = 1'b1;
                    end
                    mux_s_d   = LSB_FIRST ? (mux_s_q + 2'd1) : (mux_s_q - 2'd1);
                    bit_cnt_d = bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'd3) begin
                        word_out_d  = asm_d;
                        word_done_d = 1'b1;
                        gap_cnt_d   = 4'd0;
                        state_d     = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 4'd0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == SHIFT);
        out_last_d  = (state_d == SHIFT) && (bit_cnt_d == 2'd3);
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mux_s_q     <= 2'd0;
            mux_d_q     <= 4'd0;
            bit_cnt_q   <= 2'd0;
            gap_cnt_q   <= 4'd0;
            asm_q       <= 4'd0;
            word_out_q  <= 4'd0;
            word_done_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mux_s_q     <= mux_s_d;
            mux_d_q     <= mux_d_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            asm_q       <= asm_d;
            word_out_q  <= word_out_d;
            word_done_q <= word_done_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mux_s     = mux_s_q;
    assign mux_d     = mux_d_q;
    assign out_valid = out_valid_q;
    // The serial bit is the live mux output so it tracks mux_y while stalled.
    assign out_bit   = mux_y;
    assign out_last  = out_last_q;
    assign word_done = word_done_q;
    assign word_out  = word_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl. Three instances share clk/rst_n:
//   unit 0: LSB first, no gap (basic, backpressure, fault injection)
//   unit 1: MSB first, no gap
//   unit 2: LSB first, GAP_CYCLES=2
// Each instance drives an ideal 4:1 mux model, optionally corrupted at select 2.
module tb_mux4_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] out_ready;
    logic [2:0] out_bit;
    logic [2:0] out_last;
    logic [2:0] word_done;
    logic [2:0] err;
    logic [2:0] mux_y;
    logic [2:0] fault;
    logic [3:0] in_data  [3];
    logic [3:0] mux_d    [3];
    logic [3:0] word_out [3];
    logic [1:0] mux_s    [3];
    logic       exp_err  [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mux4_scan_ctrl #(
            .LSB_FIRST  ((gi == 1) ? 1'b0 : 1'b1),
            .GAP_CYCLES ((gi == 2) ? 2 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data[gi]),
            .mux_s     (mux_s[gi]),
            .mux_d     (mux_d[gi]),
            .mux_y     (mux_y[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_bit   (out_bit[gi]),
            .out_last  (out_last[gi]),
            .word_done (word_done[gi]),
            .word_out  (word_out[gi]),
            .err       (err[gi])
        );
        assign mux_y[gi] = mux_d[gi][mux_s[gi]] ^ (fault[gi] && (mux_s[gi] == 2'd2));
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int u);
        chk1("rst_in_ready",  in_ready[u],  1'b1);
        chk1("rst_out_valid", out_valid[u], 1'b0);
        chk1("rst_out_last",  out_last[u],  1'b0);
        chk1("rst_word_done", word_done[u], 1'b0);
        chk1("rst_err",       err[u],       1'b0);
        chk4("rst_word_out",  word_out[u],  4'h0);
        chk4("rst_mux_s",     {2'b00, mux_s[u]}, 4'h0);
        chk4("rst_mux_d",     mux_d[u],     4'h0);
    endtask

    // One word through unit u, starting and ending on a falling edge.
    // stall_at: beat index at which out_ready drops for stall_len cycles (-1 = none).
    task automatic run_word(input int u, input logic [3:0] data, input logic [3:0] exp_word,
                            input int stall_at, input int stall_len);
        logic [1:0] s;
        logic [1:0] s0;
        s0 = (u == 1) ? 2'd3 : 2'd0;
        chk1("in_ready_idle", in_ready[u], 1'b1);
        in_valid[u]  = 1'b1;
        in_data[u]   = data;
        out_ready[u] = 1'b1;
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_data[u]  = ~data;
        for (int i = 0; i < 4; i++) begin
            s = (u == 1) ? 2'(3 - i) : 2'(i);
            if (i == stall_at) begin
                out_ready[u] = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    chk4("stall_mux_s", {2'b00, mux_s[u]}, {2'b00, s});
                    chk1("stall_out_bit", out_bit[u], exp_word[s]);
                    chk1("stall_out_valid", out_valid[u], 1'b1);
                    chk1("stall_word_done", word_done[u], 1'b0);
                end
                out_ready[u] = 1'b1;
            end
            chk4("mux_s", {2'b00, mux_s[u]}, {2'b00, s});
            chk4("mux_d", mux_d[u], data);
            chk1("out_valid", out_valid[u], 1'b1);
            chk1("in_ready_busy", in_ready[u], 1'b0);
            chk1("out_bit", out_bit[u], exp_word[s]);
            chk1("out_last", out_last[u], (i == 3));
            chk1("word_done_mid", word_done[u], 1'b0);
            chk1("err_beat", err[u], exp_err[u]);
            if (exp_word[s] != data[s]) exp_err[u] = 1'b1;
            @(negedge clk);
        end
        chk1("word_done", word_done[u], 1'b1);
        chk4("word_out", word_out[u], exp_word);
        chk1("err_end", err[u], exp_err[u]);
        chk4("mux_s_wrap", {2'b00, mux_s[u]}, {2'b00, s0});
        chk1("out_valid_end", out_valid[u], 1'b0);
        chk1("in_ready_end", in_ready[u], (u != 2));
        @(negedge clk);
        chk1("word_done_pulse", word_done[u], 1'b0);
        chk4("word_out_hold", word_out[u], exp_word);
    endtask

    initial begin : main
        int n;
        int w;
        int acc_t [2];
        bit pend;
        logic [3:0] wexp;

        rst_n     = 1'b0;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        fault     = 3'b000;
        for (int u = 0; u < 3; u++) begin
            in_data[u] = 4'h0;
            exp_err[u] = 1'b0;
        end

        // Power-on reset values.
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) chk_reset(u);
        rst_n = 1'b1;
        @(negedge clk);

        // LSB first, 1011: selects 0..3, bits 1,1,0,1.
        run_word(0, 4'b1011, 4'b1011, -1, 0);
        // MSB first, 0110: selects 3..0, bits 0,1,1,0.
        run_word(1, 4'b0110, 4'b0110, -1, 0);
        // Backpressure: 3 stalled cycles after the 2nd beat.
        run_word(0, 4'b1001, 4'b1001, 2, 3);

        // Reset in the middle of a word.
        in_valid[0]  = 1'b1;
        in_data[0]   = 4'hC;
        out_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk1("pre_rst_out_valid", out_valid[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            chk_reset(u);
            exp_err[u] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1("post_rst_no_done", word_done[0], 1'b0);
            chk1("post_rst_in_ready", in_ready[0], 1'b1);
        end

        // Fault on select 2: 1111 comes back as 1011 and err sets after 3rd beat.
        fault[0] = 1'b1;
        run_word(0, 4'hF, 4'b1011, -1, 0);
        fault[0] = 1'b0;
        // A good word afterwards leaves err sticky.
        run_word(0, 4'h3, 4'h3, -1, 0);

        // Gap of 2 cycles with back-to-back words 5 then A.
        in_valid[2]  = 1'b1;
        in_data[2]   = 4'h5;
        out_ready[2] = 1'b1;
        n = 0;
        w = 0;
        pend = 1'b0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        for (int t = 0; t < 25; t++) begin
            if (pend) begin
                if (n == 1) in_data[2] = 4'hA;
                else        in_valid[2] = 1'b0;
                pend = 1'b0;
            end
            if (word_done[2]) begin
                wexp = (w == 0) ? 4'h5 : 4'hA;
                chk4("gap_word_out", word_out[2], wexp);
                w++;
            end
            if (in_valid[2] && in_ready[2] && n < 2) begin
                acc_t[n] = t;
                n++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        chk4("gap_accepts", 4'(n), 4'd2);
        chk4("gap_words", 4'(w), 4'd2);
        chk4("gap_spacing", 4'(acc_t[1] - acc_t[0]), 4'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
